// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types and constants for the radix-2^D sequential multiplier.
// Contents: FSM state enum, curve constants for the downstream reduction layer,
// default operand width B and the digit-counter width helper.
package seq_mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int B = 256;
    localparam logic [255:0] Q_P25519 = {1'b0, {247{1'b1}}, 8'hED};
    localparam logic [255:0] L_ORDER =
        256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/seq_mult_radix_if.sv
// seq_mult_radix_if: start/busy/done handshake bundle of the sequential multiplier.
// Signals: i_start, i_a[W], i_b[W] (requester -> multiplier);
//          o_busy, o_done, o_product[2W] (multiplier -> requester).
// Modports: master (requester side), slave (multiplier side).
interface seq_mult_radix_if
    import seq_mult_pkg::*;
#(parameter int W = B);
    logic           i_start;
    logic [W-1:0]   i_a;
    logic [W-1:0]   i_b;
    logic           o_busy;
    logic           o_done;
    logic [2*W-1:0] o_product;
    modport master (output i_start, i_a, i_b, input o_busy, o_done, o_product);
    modport slave  (input i_start, i_a, i_b, output o_busy, o_done, o_product);
endinterface

// File: rtl/seq_mult_digit_pp.sv
// seq_mult_digit_pp: combinational W x D partial product (multiplicand times one digit).
// Ports: i_a[W] multiplicand, i_d[D] multiplier digit, o_pp[W+D] partial product.
module seq_mult_digit_pp #(
    parameter int W = 256,
    parameter int D = 1
) (
    input  logic [W-1:0]   i_a,
    input  logic [D-1:0]   i_d,
    output logic [W+D-1:0] o_pp
);
    assign o_pp = {{D{1'b0}}, i_a} * {{W{1'b0}}, i_d};
endmodule

// File: rtl/seq_mult_radix.sv
// seq_mult_radix: sequential unsigned W x W multiplier retiring D multiplier bits per cycle.
// Ports: clk, rst_n (async, active low), bus (seq_mult_radix_if.slave: i_start, i_a, i_b,
//        o_busy, o_done, o_product).
// Optional: define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier is zero.
module seq_mult_radix
    import seq_mult_pkg::*;
#(
    parameter int W = B,
    parameter int D = 1
) (
    input logic             clk,
    input logic             rst_n,
    seq_mult_radix_if.slave bus
);
    localparam int N = W / D;
    localparam int CNT_W = cnt_width(N);

    state_t           r_state, w_state_next;
    logic [W-1:0]     r_a, r_b, w_b_next;
    logic [2*W-1:0]   r_acc, r_product, w_acc_next;
    logic [CNT_W-1:0] r_cnt;
    logic [W+D-1:0]   w_pp;
    logic             w_accept, w_last, w_finish;

    seq_mult_digit_pp #(.W(W), .D(D)) u_pp (
        .i_a  (r_a),
        .i_d  (r_b[D-1:0]),
        .o_pp (w_pp)
    );

    // Top shift is (N-1)*D = W-D, so the W+D bit partial product always fits in 2W bits.
    assign w_acc_next = r_acc + ({{(W-D){1'b0}}, w_pp} << (32'(r_cnt) * 32'(D)));
    assign w_b_next   = r_b >> D;
    assign w_last     = r_cnt == CNT_W'(N - 1);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign w_finish   = w_last || (w_b_next == '0);
`else
    assign w_finish   = w_last;
`endif
    // DONE accepts a new start just like IDLE, giving back-to-back operation.
    assign w_accept   = bus.i_start && (r_state == IDLE || r_state == DONE);

    always_comb begin
        w_state_next = r_state;
        if (w_accept)
            w_state_next = RUN;
        else if (r_state == RUN)
            w_state_next = w_finish ? DONE : RUN;
        else
            w_state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= bus.i_a;
                r_b   <= bus.i_b;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_acc <= w_acc_next;
                r_b   <= w_b_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_finish)
                    r_product <= w_acc_next;
            end
        end
    end

    assign bus.o_busy    = r_state == RUN;
    assign bus.o_done    = r_state == DONE;
    assign bus.o_product = r_product;
endmodule

// File: tb/tb_seq_mult_radix.sv
// tb_seq_mult_radix: self-checking bench for seq_mult_radix with D=1 and D=4 instances.
module tb_seq_mult_radix;
    import seq_mult_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    seq_mult_radix_if #(.W(256)) if1 ();
    seq_mult_radix_if #(.W(256)) if4 ();

    seq_mult_radix #(.W(256), .D(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    seq_mult_radix #(.W(256), .D(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [511:0] p;
    } vec_t;

    function automatic logic [511:0] model(input logic [255:0] a, input logic [255:0] b);
        return {256'b0, a} * {256'b0, b};
    endfunction

    function automatic int exp_lat(input logic [255:0] b, input int d);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int m = 0;
        for (int i = 0; i < 256; i++) if (b[i]) m = i + 1;
        return (m == 0) ? 1 : (m + d - 1) / d;
`else
        return 256 / d;
`endif
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input bit w4, input logic s, input logic [255:0] a, input logic [255:0] b);
        if (w4) begin
            if4.i_start = s; if4.i_a = a; if4.i_b = b;
        end else begin
            if1.i_start = s; if1.i_a = a; if1.i_b = b;
        end
    endtask

    function automatic logic get_done(input bit w4);
        return w4 ? if4.o_done : if1.o_done;
    endfunction

    function automatic logic get_busy(input bit w4);
        return w4 ? if4.o_busy : if1.o_busy;
    endfunction

    function automatic logic [511:0] get_prod(input bit w4);
        return w4 ? if4.o_product : if1.o_product;
    endfunction

    // Called at a negedge where the DUT can accept; returns one negedge later (after E0).
    task automatic launch(input bit w4, input logic [255:0] a, input logic [255:0] b);
        drive(w4, 1'b1, a, b);
        @(negedge clk);
        drive(w4, 1'b0, ~a, ~b);
    endtask

    // Counts cycles from acceptance to done; optionally pulses start (a=b=3) at cycle inj.
    task automatic wait_done(input bit w4, input int inj, output int lat, output int bc);
        lat = 0;
        bc = 0;
        while (!get_done(w4) && lat < 600) begin
            if (get_busy(w4)) bc++;
            drive(w4, lat == inj, 256'd3, 256'd3);
            @(negedge clk);
            lat++;
        end
        drive(w4, 1'b0, 256'd0, 256'd0);
    endtask

    task automatic run_vec(input bit w4, input string nm, input logic [255:0] a,
                           input logic [255:0] b, input logic [511:0] p);
        int lat, bc, el;
        el = exp_lat(b, w4 ? 4 : 1);
        @(negedge clk);
        launch(w4, a, b);
        wait_done(w4, -1, lat, bc);
        chk({nm, "_product"}, get_prod(w4), p);
        chk({nm, "_latency"}, 512'(lat), 512'(el));
        chk({nm, "_busy_cycles"}, 512'(bc), 512'(el));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 512'(get_done(w4)), 512'd0);
        chk({nm, "_product_hold"}, get_prod(w4), p);
    endtask

    initial begin
        vec_t tv[6];
        logic [255:0] ra, rb;
        int lat, bc, seen;

        tv[0] = '{a: 256'd2, b: 256'd2, p: 512'd4};
        tv[1] = '{a: Q_P25519, b: 256'd0, p: 512'd0};
        tv[2] = '{a: 256'd0, b: 256'd5, p: 512'd0};
        tv[3] = '{a: {256{1'b1}}, b: {256{1'b1}}, p: {{255{1'b1}}, {256{1'b0}}, 1'b1}};
        tv[4] = '{a: Q_P25519, b: 256'd2, p: {256'b0, Q_P25519} << 1};
        tv[5] = '{a: 256'd1, b: {1'b1, 255'b0}, p: {256'b0, 1'b1, 255'b0}};

        drive(1'b0, 1'b0, 256'd0, 256'd0);
        drive(1'b1, 1'b0, 256'd0, 256'd0);
        repeat (3) @(negedge clk);
        chk("reset_busy", 512'(if1.o_busy), 512'd0);
        chk("reset_done", 512'(if1.o_done), 512'd0);
        chk("reset_product", if1.o_product, 512'd0);
        chk("reset_product_d4", if4.o_product, 512'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(1'b0, $sformatf("d1_vec%0d", i), tv[i].a, tv[i].b, tv[i].p);
        run_vec(1'b1, "d4_ones", tv[3].a, tv[3].b, tv[3].p);

        for (int i = 0; i < 20; i++) begin
            ra = rnd256();
            rb = rnd256() >> $urandom_range(0, 255);
            run_vec(1'b1, $sformatf("d4_rand%0d", i), ra, rb, model(ra, rb));
        end
        for (int i = 0; i < 5; i++) begin
            ra = rnd256();
            rb = rnd256() >> $urandom_range(0, 255);
            run_vec(1'b0, $sformatf("d1_rand%0d", i), ra, rb, model(ra, rb));
        end

        // start pulsed during RUN is ignored, then back-to-back start in the DONE cycle
        @(negedge clk);
        launch(1'b0, 256'd2, 256'd2);
        wait_done(1'b0, 10, lat, bc);
        chk("ignored_start_product", if1.o_product, 512'd4);
        chk("ignored_start_latency", 512'(lat), 512'(exp_lat(256'd2, 1)));
        launch(1'b0, 256'd5, 256'd7);
        chk("b2b_busy", 512'(if1.o_busy), 512'd1);
        chk("b2b_product_stable", if1.o_product, 512'd4);
        wait_done(1'b0, -1, lat, bc);
        chk("b2b_latency", 512'(lat), 512'(exp_lat(256'd7, 1)));
        chk("b2b_product", if1.o_product, 512'd35);

        // asynchronous reset mid-operation abandons it
        @(negedge clk);
        launch(1'b0, Q_P25519, {256{1'b1}});
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 512'(if1.o_busy), 512'd0);
        chk("midrst_done", 512'(if1.o_done), 512'd0);
        chk("midrst_product", if1.o_product, 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (if1.o_done || if1.o_busy) seen++;
            @(negedge clk);
        end
        chk("midrst_no_done", 512'(seen), 512'd0);
        run_vec(1'b0, "after_rst", 256'd7, 256'd9, 512'd63);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/seq_mult_radix.md
Name: seq_mult_radix

Overview:
- Parametrised sequential unsigned multiplier; next generation of the 256-bit shift-add multiplier.
- Configurable operand width W and digit size D; retires D multiplier bits per cycle, so latency is W/D cycles.
- Uses a start/busy/done handshake and has a proper reset.
- Feeds the field-arithmetic layer (mod q / mod l reduction) of the ed25519 point-add datapath; the full 2W-bit product is passed downstream unreduced.

Parameters:
- W, 256: operand width in bits. Must be a multiple of D.
- D, 1: multiplier digit bits retired per cycle (radix 2^D). Legal values: 1, 2, 4, 8, 16.
- N, W/D (localparam): number of RUN cycles.
- CNT_W, $clog2(N+1) (localparam): digit-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on the rising edge only when the block can accept.
- a  in  W  multiplicand; captured when start is accepted.
- b  in  W  multiplier; captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse: product valid.
- product  out  2W  result; held stable from done until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal accumulator, operand registers and counter all cleared.
  - Any in-flight operation is abandoned; no done is produced for it.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch a into a_r and b into b_r; acc=0, cnt=0; go to RUN. start=0 -> stay.
  - RUN, each cycle:
    - pp = a_r * b_r[D-1:0], width W+D.
    - acc += pp << (cnt*D); acc is 2W bits and never overflows.
    - b_r >>= D; cnt++.
    - When cnt reaches N-1 on this edge: product<=acc_next, done<=1, go to DONE.
    - start is ignored in RUN: no effect, no queueing.
  - DONE, one cycle only, done=1:
    - start=1 -> accepted exactly as in IDLE (back-to-back); go to RUN.
    - start=0 -> go to IDLE.
    - done is low in the following cycle in both cases.
- Latency: start accepted at edge E0; RUN spans edges E1..EN; done is high during the cycle after edge EN. Total N cycles from acceptance to done. W=256, D=1: 256 cycles. D=4: 64 cycles.
- product changes only on the edge that asserts done, or on reset. It stays unchanged through the next RUN.
- Operands:
  - a and b may change freely after acceptance.
  - a=0 or b=0 -> product=0 after the normal latency (unless SEQ_MULT_EARLY_EXIT_EN is defined).
- Simultaneous start and rst_n low: reset wins.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN
- Defined:
  - In RUN, if the shifted b_r (after dropping the current digit) is zero, finish on this edge: product<=acc_next, done<=1, go to DONE.
  - Latency = max(1, ceil(msb_index(b)+1 / D)) cycles.
  - b=0 -> exactly 1 RUN cycle.
- Undefined: fixed latency of N cycles; the zero-detect logic is not synthesised.

Decomposition:
- Package seq_mult_pkg:
  - State enum (IDLE/RUN/DONE).
  - Curve constants Q_P25519 (2^255-19) and L_ORDER.
  - Default B=256.
  - Helper function for the counter width.
- Sub-module seq_mult_digit_pp: combinational W x D partial-product generator (a_r * digit), instantiated once.
- The top level holds the FSM, counter, accumulator and shifter.

Test Plan:
- W=256, D=1: a=2, b=2, start pulsed one cycle -> done pulses after 256 cycles; product=4; busy high for exactly 256 cycles.
- W=256, D=4: a=b=2^256-1 -> done after 64 cycles; product=2^512-2^257+1.
- W=256, D=1:
  - Pulse start again at RUN cycle 10 with a=3, b=3 -> ignored; product=4 for a=b=2.
  - Back-to-back start asserted in the DONE cycle -> second done exactly 256 cycles later.
- Reset mid-operation: drop rst_n at RUN cycle 100 -> busy, done and product become 0 immediately; no done afterwards. A new start gives the correct result with full latency.
- W=256, D=1, b=0, a=q -> product=0 after 256 cycles.
- With SEQ_MULT_EARLY_EXIT_EN defined, W=256, D=1:
  - a=q, b=2 -> done after 2 cycles; product=2q.
  - b=0 -> done after 1 cycle; product=0.
  - b=2^255 -> done after 256 cycles.
